deser_delay_calib: RTL and testbench
====================================

DESER_DELAY_CALIB -- requirements
Module: deser_delay_calib

Interface
REQ-001 SHALL have parameter TRAIN_PATTERN, default 8'hBC: idle/training byte the sensor transmits during calibration.
REQ-002 SHALL have parameter SETTLE_BITS, default 16: bit strobes discarded after each setting change; legal range 8..255.
REQ-003 SHALL have parameter WINDOW_BITS, default 256: bit strobes measured per setting; legal range 1..65535.
REQ-004 SHALL have parameter MAX_ERRORS, default 0: a setting passes when its error count is <= MAX_ERRORS.
REQ-005 SHALL have port fast_clock, input, 1: sole clock; reset reset, synchronous, active-high; clock fast_clock.
REQ-006 SHALL have port reset, input, 1: synchronous active-high reset.
REQ-007 SHALL have port start, input, 1: single-cycle calibration request.
REQ-008 SHALL have port bit_strobe, input, 1: one-cycle pulse per slow-clock bit, aligned to a new deserialiser output.
REQ-009 SHALL have port data_bit, input, 1: deserialiser data_out.
REQ-010 SHALL have port delay, output, 4: sampling delay driven to the deserialiser.
REQ-011 SHALL have port delay2steps, output, 1: edge-detect mode driven to the deserialiser.
REQ-012 SHALL have port busy, output, 1: high from start acceptance until done.
REQ-013 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-014 SHALL have port calib_ok, output, 1: last calibration found at least one passing setting.

Function
REQ-015 SHALL index settings as s = {delay2steps, delay} (0..31) and sweep s = 0..31 in ascending order.
REQ-016 SHALL implement states IDLE, SETTLE, MEASURE, EVAL, DONE.
REQ-017 IDLE: start=1 -> SETTLE with s=0, busy=1 next cycle; start while busy SHALL be ignored.
REQ-018 SETTLE: count SETTLE_BITS bit_strobes, then -> MEASURE with error counter cleared.
REQ-019 MEASURE: per bit_strobe, shift data_bit into an 8-bit window (MSB first); flag an error when the window matches no rotation of TRAIN_PATTERN.
REQ-020 SHALL saturate the 16-bit error counter at 16'hFFFF.
REQ-021 After WINDOW_BITS strobes SHALL record pass bit map[s]; s<31 -> s+1, SETTLE; s=31 -> EVAL.
REQ-022 EVAL SHALL scan map one bit per cycle (32 cycles), tracking the longest run of consecutive passes; runs SHALL NOT cross s=15/16 and SHALL NOT wrap 31->0.
REQ-023 Chosen setting SHALL be run_start + (run_len-1)/2 (truncating); equal-length runs resolve to the lowest run_start.
REQ-024 No passing setting: calib_ok=0 and delay/delay2steps SHALL return to their pre-start values.
REQ-025 DONE SHALL last one cycle: done=1, busy=0 next cycle, chosen setting on outputs, -> IDLE.
REQ-026 delay/delay2steps SHALL change only on state transitions, never mid-window.
REQ-027 bit_strobe in IDLE, EVAL or DONE SHALL be ignored.

Reset
REQ-028 reset SHALL override all activity, including mid-sweep, -> IDLE next cycle.
REQ-029 Reset values: delay=0, delay2steps=0, busy=0, done=0, calib_ok=0, map=0, counters=0.

Configuration
REQ-030 With DESER_CALIB_MAP_EN defined SHALL add output pass_map[31:0] holding the last completed map (reset 0, updated on entering EVAL).
REQ-031 Without DESER_CALIB_MAP_EN the port and its register SHALL be absent; all other behaviour identical.

Structure
REQ-032 Package deser_calib_pkg SHALL hold the state enum, NUM_SETTINGS=32 and the 5-bit setting index type.
REQ-033 Sub-module deser_pattern_checker SHALL hold the 8-bit window and rotation compare, outputting a per-strobe error flag.

Verification
REQ-034 Clean 0xBC stream for settings 5..11 only, errors elsewhere -> delay=8, delay2steps=0, calib_ok=1, single done pulse.
REQ-035 Passes at 2..4 and 20..26 -> run 20..26 chosen: delay=7, delay2steps=1.
REQ-036 Passes at 14..17 only -> runs 14..15 and 16..17 tie, lowest wins: delay=14, delay2steps=0.
REQ-037 All settings failing, pre-start delay=3 -> calib_ok=0, delay=3, delay2steps=0.
REQ-038 reset asserted during MEASURE at s=9 -> next cycle IDLE, busy=0, delay=0; a new start repeats the full sweep from s=0.
REQ-039 start pulsed during SETTLE -> ignored; exactly one done pulse, 32*(SETTLE_BITS+WINDOW_BITS) strobes consumed.

Source files
------------

// File: rtl/deser_calib_pkg.sv
// deser_calib_pkg: shared state encoding and setting index type for the delay calibrator
package deser_calib_pkg;
   localparam int NUM_SETTINGS = 32;
   typedef logic [4:0] setting_t;
   typedef enum logic [2:0] {IDLE, SETTLE, MEASURE, EVAL, DONE} state_t;
endpackage

// File: rtl/deser_pattern_checker.sv
// deser_pattern_checker: 8-bit sliding window flagging strobes whose window is no rotation of the training byte
module deser_pattern_checker #(
   parameter logic [7:0] TRAIN_PATTERN = 8'hBC
) (
   input  logic fast_clock,
   input  logic reset,
   input  logic shift_i,
   input  logic data_i,
   output logic err_o
);
   logic [7:0] window_q, window_d;
   logic [15:0] dbl;
   logic match;
   assign window_d = {window_q[6:0], data_i};
   assign dbl = {TRAIN_PATTERN, TRAIN_PATTERN};
   assign err_o = shift_i & ~match;
   // compare the incoming window against every rotation of the training byte
   always_comb begin
      match = 1'b0;
      for (int r = 0; r < 8; r++) match = match | (window_d == dbl[r +: 8]);
   end
   // window shifts MSB first on every accepted strobe
   always_ff @(posedge fast_clock) begin
      if (reset) window_q <= '0;
      else if (shift_i) window_q <= window_d;
   end
endmodule

// File: rtl/deser_delay_calib.sv
// deser_delay_calib: sweeps 32 deserialiser delay settings and centres on the longest passing run (optional DESER_CALIB_MAP_EN adds pass_map)
module deser_delay_calib
   import deser_calib_pkg::*;
#(
   parameter logic [7:0] TRAIN_PATTERN = 8'hBC,
   parameter int SETTLE_BITS = 16,
   parameter int WINDOW_BITS = 256,
   parameter int MAX_ERRORS = 0
) (
   input  logic fast_clock,
   input  logic reset,
   input  logic start,
   input  logic bit_strobe,
   input  logic data_bit,
   output logic [3:0] delay,
   output logic delay2steps,
   output logic busy,
   output logic done,
   output logic calib_ok
`ifdef DESER_CALIB_MAP_EN
   ,
   output logic [31:0] pass_map
`endif
);
   localparam logic [7:0] LAST_S = 8'(SETTLE_BITS - 1);
   localparam logic [15:0] LAST_W = 16'(WINDOW_BITS - 1);
   localparam setting_t LAST_SET = setting_t'(NUM_SETTINGS - 1);
   state_t state_q, state_d;
   setting_t set_q, set_d, saved_q, saved_d, scan_q, scan_d;
   setting_t cur_start_q, cur_start_d, best_start_q, best_start_d, ext_start;
   logic [5:0] cur_len_q, cur_len_d, best_len_q, best_len_d, run_len, ext_len;
   logic [7:0] settle_q, settle_d;
   logic [15:0] win_q, win_d, err_q, err_d, err_next;
   logic [31:0] map_q, map_d;
   logic ok_q, ok_d, err, pass, shift;
   assign shift = bit_strobe & (state_q == SETTLE || state_q == MEASURE);
   deser_pattern_checker #(.TRAIN_PATTERN(TRAIN_PATTERN)) u_chk (
      .fast_clock(fast_clock),
      .reset(reset),
      .shift_i(shift),
      .data_i(data_bit),
      .err_o(err)
   );
   assign err_next = (err && err_q != 16'hFFFF) ? err_q + 16'd1 : err_q;
   assign pass = {16'd0, err_next} <= 32'(MAX_ERRORS);
   // a run never continues across the 15/16 boundary between delay2steps modes
   assign run_len = (scan_q == 5'd16) ? 6'd0 : cur_len_q;
   assign ext_len = run_len + 6'd1;
   assign ext_start = (run_len == 6'd0) ? scan_q : cur_start_q;
   assign delay = set_q[3:0];
   assign delay2steps = set_q[4];
   assign busy = state_q != IDLE;
   assign done = state_q == DONE;
   assign calib_ok = ok_q;
   // sweep sequencing, window measurement and pass-map scan
   always_comb begin
      state_d = state_q;
      set_d = set_q;
      saved_d = saved_q;
      scan_d = scan_q;
      cur_start_d = cur_start_q;
      cur_len_d = cur_len_q;
      best_start_d = best_start_q;
      best_len_d = best_len_q;
      settle_d = settle_q;
      win_d = win_q;
      err_d = err_q;
      map_d = map_q;
      ok_d = ok_q;
      case (state_q)
         IDLE: if (start) begin
            state_d = SETTLE;
            saved_d = set_q;
            set_d = '0;
            settle_d = '0;
         end
         SETTLE: if (bit_strobe) begin
            settle_d = settle_q + 8'd1;
            if (settle_q == LAST_S) begin
               state_d = MEASURE;
               settle_d = '0;
               win_d = '0;
               err_d = '0;
            end
         end
         MEASURE: if (bit_strobe) begin
            win_d = win_q + 16'd1;
            err_d = err_next;
            if (win_q == LAST_W) begin
               map_d[set_q] = pass;
               win_d = '0;
               if (set_q == LAST_SET) begin
                  state_d = EVAL;
                  scan_d = '0;
                  cur_start_d = '0;
                  cur_len_d = '0;
                  best_start_d = '0;
                  best_len_d = '0;
               end else begin
                  state_d = SETTLE;
                  set_d = set_q + 5'd1;
                  settle_d = '0;
               end
            end
         end
         EVAL: begin
            scan_d = scan_q + 5'd1;
            cur_len_d = map_q[scan_q] ? ext_len : 6'd0;
            cur_start_d = map_q[scan_q] ? ext_start : cur_start_q;
            if (map_q[scan_q] && ext_len > best_len_q) begin
               best_len_d = ext_len;
               best_start_d = ext_start;
            end
            if (scan_q == LAST_SET) begin
               state_d = DONE;
               ok_d = best_len_d != 6'd0;
               set_d = ok_d ? best_start_d + 5'((best_len_d - 6'd1) >> 1) : saved_q;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   // state and datapath registers
   always_ff @(posedge fast_clock) begin
      if (reset) begin
         state_q <= IDLE;
         set_q <= '0;
         saved_q <= '0;
         scan_q <= '0;
         cur_start_q <= '0;
         cur_len_q <= '0;
         best_start_q <= '0;
         best_len_q <= '0;
         settle_q <= '0;
         win_q <= '0;
         err_q <= '0;
         map_q <= '0;
         ok_q <= 1'b0;
      end else begin
         state_q <= state_d;
         set_q <= set_d;
         saved_q <= saved_d;
         scan_q <= scan_d;
         cur_start_q <= cur_start_d;
         cur_len_q <= cur_len_d;
         best_start_q <= best_start_d;
         best_len_q <= best_len_d;
         settle_q <= settle_d;
         win_q <= win_d;
         err_q <= err_d;
         map_q <= map_d;
         ok_q <= ok_d;
      end
   end
`ifdef DESER_CALIB_MAP_EN
   logic [31:0] pass_map_q;
   assign pass_map = pass_map_q;
   // snapshot the completed map as the sweep hands over to the scan
   always_ff @(posedge fast_clock) begin
      if (reset) pass_map_q <= '0;
      else if (state_q == MEASURE && state_d == EVAL) pass_map_q <= map_d;
   end
`endif
endmodule

// File: tb/tb_deser_delay_calib.sv
// tb_deser_delay_calib: directed calibration scenarios against a sensor model that passes only masked settings
module tb_deser_delay_calib;
   localparam int SB = 8;
   localparam int WB = 16;
   localparam int SWEEP = 32 * (SB + WB);
   logic fast_clock = 1'b0, reset = 1'b1, start = 1'b0, bit_strobe = 1'b0, data_bit = 1'b0;
   logic [3:0] delay;
   logic delay2steps, busy, done, calib_ok;
`ifdef DESER_CALIB_MAP_EN
   logic [31:0] pass_map;
`endif
   int n_checks = 0, n_errors = 0, done_cnt = 0, strobe_left = 0, gap = 0, tx_pos = 0;
   logic [31:0] pass_mask = '0;
   logic [7:0] pat = 8'hBC;
   deser_delay_calib #(.SETTLE_BITS(SB), .WINDOW_BITS(WB)) dut (
      .fast_clock(fast_clock),
      .reset(reset),
      .start(start),
      .bit_strobe(bit_strobe),
      .data_bit(data_bit),
      .delay(delay),
      .delay2steps(delay2steps),
      .busy(busy),
      .done(done),
      .calib_ok(calib_ok)
`ifdef DESER_CALIB_MAP_EN
      ,
      .pass_map(pass_map)
`endif
   );
   always #5 fast_clock = ~fast_clock;
   always @(negedge fast_clock) if (done) done_cnt <= done_cnt + 1;
   // sensor model: strobe every third cycle, clean training stream only at masked settings
   initial begin
      forever begin
         @(negedge fast_clock);
         if (strobe_left > 0 && gap == 2) begin
            gap = 0;
            strobe_left--;
            bit_strobe = 1'b1;
            data_bit = pass_mask[{delay2steps, delay}] ? pat[7 - tx_pos] : 1'b0;
            tx_pos = (tx_pos + 1) % 8;
         end else begin
            bit_strobe = 1'b0;
            if (gap < 2) gap++;
         end
      end
   end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic pulse_start();
      @(negedge fast_clock);
      start = 1'b1;
      @(negedge fast_clock);
      start = 1'b0;
   endtask
   task automatic wait_done(input int limit);
      for (int i = 0; i < limit && !done; i++) @(negedge fast_clock);
   endtask
   task automatic run_calib(input string tag, input logic [31:0] mask, input logic [4:0] exp_set, input logic exp_ok);
      int base;
      base = done_cnt;
      pass_mask = mask;
      strobe_left = 1000000;
      pulse_start();
      check({tag, "_busy"}, 32'(busy), 1);
      check({tag, "_s0"}, {27'd0, delay2steps, delay}, 0);
      wait_done(4 * SWEEP);
      check({tag, "_done"}, 32'(done), 1);
      check({tag, "_set"}, {27'd0, delay2steps, delay}, {27'd0, exp_set});
      check({tag, "_ok"}, 32'(calib_ok), 32'(exp_ok));
`ifdef DESER_CALIB_MAP_EN
      check({tag, "_map"}, pass_map, mask);
`endif
      @(negedge fast_clock);
      check({tag, "_done_low"}, 32'(done), 0);
      check({tag, "_idle"}, 32'(busy), 0);
      check({tag, "_pulses"}, 32'(done_cnt - base), 1);
      strobe_left = 0;
   endtask
   initial begin
      int base;
      repeat (3) @(negedge fast_clock);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_ok", 32'(calib_ok), 0);
      check("rst_set", {27'd0, delay2steps, delay}, 0);
      reset = 1'b0;
      run_calib("run5_11", 32'h0000_0FE0, 5'd8, 1'b1);
      run_calib("two_runs", 32'h07F0_001C, 5'd23, 1'b1);
      run_calib("tie", 32'h0003_C000, 5'd14, 1'b1);
      run_calib("pre3", 32'h0000_001C, 5'd3, 1'b1);
      run_calib("allfail", 32'h0000_0000, 5'd3, 1'b0);
      pass_mask = 32'h0000_0FE0;
      strobe_left = 1000000;
      pulse_start();
      for (int i = 0; i < 4 * SWEEP && {delay2steps, delay} != 5'd9; i++) @(negedge fast_clock);
      check("reach_s9", {27'd0, delay2steps, delay}, 9);
      repeat (30) @(negedge fast_clock);
      reset = 1'b1;
      @(negedge fast_clock);
      check("mid_rst_busy", 32'(busy), 0);
      check("mid_rst_set", {27'd0, delay2steps, delay}, 0);
      check("mid_rst_done", 32'(done), 0);
      check("mid_rst_ok", 32'(calib_ok), 0);
      reset = 1'b0;
      strobe_left = 0;
      run_calib("after_rst", 32'h0000_0FE0, 5'd8, 1'b1);
      base = done_cnt;
      pass_mask = 32'h07F0_001C;
      pulse_start();
      strobe_left = SWEEP - 1;
      repeat (10) @(negedge fast_clock);
      start = 1'b1;
      @(negedge fast_clock);
      start = 1'b0;
      for (int i = 0; i < 4 * SWEEP && strobe_left > 0; i++) @(negedge fast_clock);
      repeat (100) @(negedge fast_clock);
      check("short_no_done", 32'(done_cnt - base), 0);
      check("short_busy", 32'(busy), 1);
      strobe_left = 1;
      wait_done(200);
      check("last_done", 32'(done), 1);
      check("last_set", {27'd0, delay2steps, delay}, 23);
      @(negedge fast_clock);
      check("last_pulses", 32'(done_cnt - base), 1);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
